// File: rtl/reg_file_if.sv
// Register-file bus: two read-address ports with a shared read enable, one write
// port, and the two registered read-data returns.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1Addr;
    logic [ADDR_W-1:0] rs2Addr;
    logic              rdEn;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    modport master (
        output rs1Addr, rs2Addr, rdEn, wrEn, wrAddr, wrData,
        input  rd1, rd2
    );

    modport slave (
        input  rs1Addr, rs2Addr, rdEn, wrEn, wrAddr, wrData,
        output rd1, rd2
    );
endinterface

// File: rtl/reg_file.sv
// Datapath register file: 2^ADDR_W x DATA_W, register 0 reads as zero, two registered
// read ports. Define REGFILE_BYPASS_EN for write-first same-edge reads (default read-first).
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1Q;
    logic [DATA_W-1:0] rd2Q;
    logic [DATA_W-1:0] rd1Next;
    logic [DATA_W-1:0] rd2Next;
    logic              wrLive;

    assign wrLive = bus.wrEn && (bus.wrAddr != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrLive) begin
            mem[bus.wrAddr] <= bus.wrData;
        end
    end

    always_comb begin
        rd1Next = (bus.rs1Addr == '0) ? '0 : mem[bus.rs1Addr];
        rd2Next = (bus.rs2Addr == '0) ? '0 : mem[bus.rs2Addr];
`ifdef REGFILE_BYPASS_EN
        // wrLive already excludes address 0, so a read of r0 can never be bypassed.
        if (wrLive && (bus.rs1Addr == bus.wrAddr)) begin
            rd1Next = bus.wrData;
        end
        if (wrLive && (bus.rs2Addr == bus.wrAddr)) begin
            rd2Next = bus.wrData;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1Q <= '0;
            rd2Q <= '0;
        end else if (bus.rdEn) begin
            rd1Q <= rd1Next;
            rd2Q <= rd2Next;
        end
    end

    assign bus.rd1 = rd1Q;
    assign bus.rd2 = rd2Q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_reg_file;
    logic clk;
    logic rst_n;

    int assertions = 0;
    int failures   = 0;

    logic [31:0] model [32];
    logic [31:0] expRd1;
    logic [31:0] expRd2;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wrEn && bus.wrAddr == a) return bus.wrData;
`endif
        return model[a];
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        expRd1 = 32'd0;
        expRd2 = 32'd0;
    endtask

    // One clock: update the model from the inputs seen before the edge, then sample after it.
    task automatic step();
        logic [31:0] n1;
        logic [31:0] n2;
        n1 = expRd1;
        n2 = expRd2;
        if (bus.rdEn) begin
            n1 = modelRead(bus.rs1Addr);
            n2 = modelRead(bus.rs2Addr);
        end
        if (bus.wrEn && bus.wrAddr != 5'd0) model[bus.wrAddr] = bus.wrData;
        @(posedge clk);
        #1;
        expRd1 = n1;
        expRd2 = n2;
    endtask

    task automatic idleInputs();
        bus.rdEn    = 1'b0;
        bus.wrEn    = 1'b0;
        bus.rs1Addr = 5'd0;
        bus.rs2Addr = 5'd0;
        bus.wrAddr  = 5'd0;
        bus.wrData  = 32'd0;
    endtask

    task automatic test_reset();
        // Power-on reset state
        assertions++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            failures++;
            $display("[TB] FAIL por_outputs: rd1=%h rd2=%h expected 00000000", bus.rd1, bus.rd2);
        end
        rst_n = 1'b1;
        #2;
        bus.wrEn = 1'b1; bus.wrAddr = 5'd5; bus.wrData = 32'hDEADBEEF;
        step();
        bus.wrEn = 1'b0; bus.rdEn = 1'b1; bus.rs1Addr = 5'd5; bus.rs2Addr = 5'd5;
        step();
        assertions++;
        if (bus.rd1 !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL pre_reset_rd1: got %h expected deadbeef", bus.rd1);
        end
        // Assert reset between edges and look before the next edge
        #3;
        rst_n = 1'b0;
        modelClear();
        #1;
        assertions++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: rd1=%h rd2=%h expected 00000000", bus.rd1, bus.rd2);
        end
        #2;
        rst_n = 1'b1;
        step();
        assertions++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            failures++;
            $display("[TB] FAIL r5_after_reset: rd1=%h rd2=%h expected 00000000", bus.rd1, bus.rd2);
        end
        idleInputs();
    endtask

    task automatic test_basic();
        bus.wrEn = 1'b1; bus.wrAddr = 5'd3; bus.wrData = 32'h00000001;
        step();
        bus.wrAddr = 5'd7; bus.wrData = 32'h00000002;
        step();
        bus.wrEn = 1'b0; bus.rdEn = 1'b1; bus.rs1Addr = 5'd3; bus.rs2Addr = 5'd7;
        step();
        assertions++;
        if (bus.rd1 !== 32'h00000001) begin
            failures++;
            $display("[TB] FAIL basic_rd1: got %h expected 00000001", bus.rd1);
        end
        assertions++;
        if (bus.rd2 !== 32'h00000002) begin
            failures++;
            $display("[TB] FAIL basic_rd2_e1: got %h expected 00000002", bus.rd2);
        end
    endtask

    task automatic test_stall();
        bus.rdEn = 1'b0; bus.rs2Addr = 5'd3;
        bus.wrEn = 1'b1; bus.wrAddr = 5'd7; bus.wrData = 32'h00000055;
        step();
        bus.wrEn = 1'b0;
        step();
        assertions++;
        if (bus.rd2 !== 32'h00000002 || bus.rd1 !== 32'h00000001) begin
            failures++;
            $display("[TB] FAIL stall_hold: rd1=%h rd2=%h expected 00000001/00000002", bus.rd1, bus.rd2);
        end
        bus.rdEn = 1'b1; bus.rs2Addr = 5'd7;
        step();
        assertions++;
        if (bus.rd2 !== 32'h00000055) begin
            failures++;
            $display("[TB] FAIL stall_write: got %h expected 00000055", bus.rd2);
        end
    endtask

    task automatic test_reg0();
        bus.rdEn = 1'b0;
        bus.wrEn = 1'b1; bus.wrAddr = 5'd0; bus.wrData = 32'hFFFFFFFF;
        step();
        bus.wrEn = 1'b0; bus.rdEn = 1'b1; bus.rs1Addr = 5'd0; bus.rs2Addr = 5'd0;
        step();
        assertions++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reg0_read: rd1=%h rd2=%h expected 00000000", bus.rd1, bus.rd2);
        end
        // Same-edge write and read of r0 must not bypass
        bus.rs1Addr = 5'd3; bus.rs2Addr = 5'd3;
        step();
        bus.wrEn = 1'b1; bus.wrAddr = 5'd0; bus.wrData = 32'hA5A5A5A5;
        bus.rs1Addr = 5'd0; bus.rs2Addr = 5'd0;
        step();
        assertions++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reg0_same_edge: rd1=%h rd2=%h expected 00000000", bus.rd1, bus.rd2);
        end
        idleInputs();
    endtask

    task automatic test_hazard();
        logic [31:0] want;
        bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 32'h00000011;
        step();
        bus.wrData = 32'h00000022; bus.rdEn = 1'b1; bus.rs1Addr = 5'd9; bus.rs2Addr = 5'd3;
        step();
`ifdef REGFILE_BYPASS_EN
        want = 32'h00000022;
`else
        want = 32'h00000011;
`endif
        assertions++;
        if (bus.rd1 !== want) begin
            failures++;
            $display("[TB] FAIL hazard_rd1: got %h expected %h", bus.rd1, want);
        end
        assertions++;
        if (bus.rd2 !== 32'h00000001) begin
            failures++;
            $display("[TB] FAIL hazard_rd2_unaffected: got %h expected 00000001", bus.rd2);
        end
        bus.wrEn = 1'b0; bus.rs2Addr = 5'd9;
        step();
        assertions++;
        if (bus.rd1 !== 32'h00000022 || bus.rd2 !== 32'h00000022) begin
            failures++;
            $display("[TB] FAIL hazard_next_read: rd1=%h rd2=%h expected 00000022", bus.rd1, bus.rd2);
        end
        idleInputs();
    endtask

    task automatic test_sweep();
        logic [31:0] want1;
        logic [31:0] want2;
        bus.wrEn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.wrAddr = 5'(i);
            bus.wrData = 32'(i) * 32'h01010101;
            step();
        end
        bus.wrEn = 1'b0; bus.rdEn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rs1Addr = 5'(i);
            bus.rs2Addr = 5'(31 - i);
            step();
            want1 = 32'(i) * 32'h01010101;
            want2 = 32'(31 - i) * 32'h01010101;
            assertions++;
            if (bus.rd1 !== want1 || bus.rd2 !== want2) begin
                failures++;
                $display("[TB] FAIL sweep_%0d: rd1=%h rd2=%h expected %h/%h", i, bus.rd1, bus.rd2, want1, want2);
            end
        end
        idleInputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.rdEn    = ($urandom_range(0, 3) != 0);
            bus.wrEn    = ($urandom_range(0, 2) != 0);
            bus.rs1Addr = 5'($urandom_range(0, 7));
            bus.rs2Addr = 5'($urandom_range(0, 7));
            bus.wrAddr  = 5'($urandom_range(0, 7));
            bus.wrData  = $urandom;
            step();
            assertions++;
            if (bus.rd1 !== expRd1 || bus.rd2 !== expRd2) begin
                failures++;
                $display("[TB] FAIL random_%0d: rd1=%h rd2=%h expected %h/%h", c, bus.rd1, bus.rd2, expRd1, expRd2);
            end
        end
        idleInputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idleInputs();
        modelClear();
        #12;
        test_reset();
        test_basic();
        test_stall();
        test_reg0();
        test_hazard();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
